// File: rtl/apu_pkg.sv
// Shared APU constants and types: frame-sequencer step decode and envelope direction.
package apu_pkg;

    // Bit n set means frame step n clocks the length counters.
    localparam logic [7:0] FS_LENGTH_STEPS = 8'b0101_0101;
    // Frame step that clocks the volume envelopes.
    localparam logic [2:0] FS_ENV_STEP     = 3'd7;
    // Full length count loaded by NR41 = 0 or by a trigger on an expired counter.
    localparam logic [6:0] LEN_MAX         = 7'd64;

    typedef enum logic {
        ENV_DOWN = 1'b0,
        ENV_UP   = 1'b1
    } env_dir_t;

endpackage

// File: rtl/volume_envelope.sv
// NR42 volume envelope: volume register, period timer and the direction/period
// latches captured on trigger.
module volume_envelope
    import apu_pkg::*;
(
    input  logic       system_clock_i,
    input  logic       reset_n_i,
    input  logic       trigger_i,
    input  logic       env_clock_i,
    input  logic [7:0] nr42_i,
    output logic [3:0] volume_o
);

    logic [3:0] volume_q, volume_d;
    logic [3:0] timer_q, timer_d;
    logic [2:0] period_q, period_d;
    env_dir_t   dir_q, dir_d;

    // Next-state: trigger reloads everything from NR42, otherwise step on envelope clocks.
    always_comb begin
        volume_d = volume_q;
        timer_d  = timer_q;
        period_d = period_q;
        dir_d    = dir_q;
        if (trigger_i) begin
            volume_d = nr42_i[7:4];
            dir_d    = env_dir_t'(nr42_i[3]);
            period_d = nr42_i[2:0];
            timer_d  = (nr42_i[2:0] == 3'd0) ? 4'd8 : {1'b0, nr42_i[2:0]};
        end else if (env_clock_i && (period_q != 3'd0)) begin
            if (timer_q <= 4'd1) begin
                timer_d = {1'b0, period_q};
                if ((dir_q == ENV_UP) && (volume_q != 4'd15)) begin
                    volume_d = volume_q + 4'd1;
                end else if ((dir_q == ENV_DOWN) && (volume_q != 4'd0)) begin
                    volume_d = volume_q - 4'd1;
                end
            end else begin
                timer_d = timer_q - 4'd1;
            end
        end
    end

    // Envelope state registers.
    always_ff @(posedge system_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            volume_q <= 4'd0;
            timer_q  <= 4'd0;
            period_q <= 3'd0;
            dir_q    <= ENV_DOWN;
        end else begin
            volume_q <= volume_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            dir_q    <= dir_d;
        end
    end

    assign volume_o = volume_q;

endmodule

// File: rtl/noise_envelope_length.sv
// Channel-4 back end: frame step counter, NR41 length counter, DAC gating and the
// registered amplitude output driven from the volume envelope.
module noise_envelope_length
    import apu_pkg::*;
(
    input  logic       system_clock_i,
    input  logic       reset_n_i,
    input  logic       frame_tick_i,
    input  logic       noise_bit_i,
    input  logic [5:0] nr41_i,
    input  logic       nr41_write_i,
    input  logic [7:0] nr42_i,
    input  logic       nr42_write_i,
    input  logic [1:0] nr44_i,
    input  logic       nr44_write_i,
    output logic [3:0] amplitude_o,
    output logic       channel_on_o,
    output logic       restart_o
);

    logic [2:0] fs_step_q, fs_step_d;
    logic [6:0] len_cnt_q, len_cnt_d;
    logic       len_en_q, len_en_d;
    logic [7:0] nr42_q, nr42_d;
    logic       channel_on_q, channel_on_d;
    logic       restart_q;
    logic [3:0] amplitude_q;
    logic [3:0] volume;

    logic       trigger;
    logic       len_clock;
    logic       env_clock;
    logic       len_dec;
    logic       dac_on;
    logic [7:0] nr42_eff;

    // A write in the same cycle as a trigger must be seen by that trigger.
    assign nr42_eff  = nr42_write_i ? nr42_i : nr42_q;
    assign dac_on    = (nr42_eff[7:3] != 5'd0);
    assign trigger   = nr44_write_i & nr44_i[1];
    assign len_clock = frame_tick_i & FS_LENGTH_STEPS[fs_step_q];
    assign env_clock = frame_tick_i & (fs_step_q == FS_ENV_STEP) & ~trigger;
    assign len_dec   = len_clock & len_en_q & (len_cnt_q != 7'd0) & ~trigger & ~nr41_write_i;

    // Next-state for frame step, length counter, latches and channel status.
    always_comb begin
        fs_step_d    = frame_tick_i ? fs_step_q + 3'd1 : fs_step_q;
        nr42_d       = nr42_eff;
        len_en_d     = nr44_write_i ? nr44_i[0] : len_en_q;
        len_cnt_d    = len_cnt_q;
        channel_on_d = channel_on_q;

        if (nr41_write_i) begin
            len_cnt_d = LEN_MAX - {1'b0, nr41_i};
        end else if (trigger && (len_cnt_q == 7'd0)) begin
            len_cnt_d = LEN_MAX;
        end else if (len_dec) begin
            len_cnt_d = len_cnt_q - 7'd1;
        end

        if (len_dec && (len_cnt_q == 7'd1)) begin
            channel_on_d = 1'b0;
        end
        if (trigger) begin
            channel_on_d = 1'b1;
        end
        if (!dac_on) begin
            channel_on_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge system_clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fs_step_q    <= 3'd0;
            len_cnt_q    <= 7'd0;
            len_en_q     <= 1'b0;
            nr42_q       <= 8'd0;
            channel_on_q <= 1'b0;
            restart_q    <= 1'b0;
            amplitude_q  <= 4'd0;
        end else begin
            fs_step_q    <= fs_step_d;
            len_cnt_q    <= len_cnt_d;
            len_en_q     <= len_en_d;
            nr42_q       <= nr42_d;
            channel_on_q <= channel_on_d;
            restart_q    <= trigger;
            amplitude_q  <= (channel_on_q & noise_bit_i) ? volume : 4'd0;
        end
    end

    volume_envelope u_volume_envelope (
        .system_clock_i (system_clock_i),
        .reset_n_i      (reset_n_i),
        .trigger_i      (trigger),
        .env_clock_i    (env_clock),
        .nr42_i         (nr42_eff),
        .volume_o       (volume)
    );

    assign amplitude_o  = amplitude_q;
    assign channel_on_o = channel_on_q;
    assign restart_o    = restart_q;

endmodule

// File: tb/tb_noise_envelope_length.sv
// Directed bench for noise_envelope_length: length, envelope, DAC gating and priorities.
module tb_noise_envelope_length;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       noise_bit = 1'b0;
    logic [5:0] nr41 = 6'd0;
    logic       nr41_write = 1'b0;
    logic [7:0] nr42 = 8'd0;
    logic       nr42_write = 1'b0;
    logic [1:0] nr44 = 2'd0;
    logic       nr44_write = 1'b0;
    logic [3:0] amplitude;
    logic       channel_on;
    logic       restart;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    noise_envelope_length dut (
        .system_clock_i (clk),
        .reset_n_i      (reset_n),
        .frame_tick_i   (frame_tick),
        .noise_bit_i    (noise_bit),
        .nr41_i         (nr41),
        .nr41_write_i   (nr41_write),
        .nr42_i         (nr42),
        .nr42_write_i   (nr42_write),
        .nr44_i         (nr44),
        .nr44_write_i   (nr44_write),
        .amplitude_o    (amplitude),
        .channel_on_o   (channel_on),
        .restart_o      (restart)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
        end
        frame_tick = 1'b0;
    endtask

    task automatic write41(input logic [5:0] v);
        nr41 = v;
        nr41_write = 1'b1;
        cyc();
        nr41_write = 1'b0;
    endtask

    task automatic write42(input logic [7:0] v);
        nr42 = v;
        nr42_write = 1'b1;
        cyc();
        nr42_write = 1'b0;
    endtask

    task automatic trig(input logic len_en);
        nr44 = {1'b1, len_en};
        nr44_write = 1'b1;
        cyc();
        nr44_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (amplitude !== 4'd0) begin
            fails++; $display("FAIL reset_amp got %0d want 0", amplitude);
        end
        tests++;
        if (channel_on !== 1'b0) begin
            fails++; $display("FAIL reset_on got %b want 0", channel_on);
        end
        tests++;
        if (restart !== 1'b0) begin
            fails++; $display("FAIL reset_restart got %b want 0", restart);
        end
    endtask

    task automatic test_trigger();
        noise_bit = 1'b1;
        write41(6'd0);
        write42(8'hF0);
        trig(1'b1);
        tests++;
        if (channel_on !== 1'b1) begin
            fails++; $display("FAIL trig_on got %b want 1", channel_on);
        end
        tests++;
        if (restart !== 1'b1) begin
            fails++; $display("FAIL trig_restart got %b want 1", restart);
        end
        cyc();
        tests++;
        if (amplitude !== 4'd15) begin
            fails++; $display("FAIL trig_amp got %0d want 15", amplitude);
        end
        tests++;
        if (restart !== 1'b0) begin
            fails++; $display("FAIL trig_restart_once got %b want 0", restart);
        end
    endtask

    // 64 length clocks: the 64th falls on the 127th tick counted from fs_step 0.
    task automatic test_length();
        ticks(126);
        tests++;
        if (channel_on !== 1'b1) begin
            fails++; $display("FAIL len_63 got %b want 1", channel_on);
        end
        ticks(1);
        tests++;
        if (channel_on !== 1'b0) begin
            fails++; $display("FAIL len_64 got %b want 0", channel_on);
        end
        cyc();
        tests++;
        if (amplitude !== 4'd0) begin
            fails++; $display("FAIL len_amp got %0d want 0", amplitude);
        end
    endtask

    task automatic test_env_up();
        do_reset();
        noise_bit = 1'b1;
        write42(8'h0A);
        trig(1'b0);
        cyc();
        tests++;
        if (amplitude !== 4'd0) begin
            fails++; $display("FAIL envup_start got %0d want 0", amplitude);
        end
        for (int i = 1; i <= 15; i++) begin
            ticks(16);
            cyc();
            tests++;
            if (amplitude !== 4'(i)) begin
                fails++; $display("FAIL envup_step%0d got %0d want %0d", i, amplitude, i);
            end
        end
        ticks(32);
        cyc();
        tests++;
        if (amplitude !== 4'd15) begin
            fails++; $display("FAIL envup_hold got %0d want 15", amplitude);
        end
    endtask

    task automatic test_env_down();
        do_reset();
        noise_bit = 1'b1;
        write42(8'h71);
        trig(1'b0);
        ticks(48);
        cyc();
        tests++;
        if (amplitude !== 4'd1) begin
            fails++; $display("FAIL envdn_6 got %0d want 1", amplitude);
        end
        ticks(16);
        cyc();
        tests++;
        if (amplitude !== 4'd0) begin
            fails++; $display("FAIL envdn_hold0 got %0d want 0", amplitude);
        end
        tests++;
        if (channel_on !== 1'b1) begin
            fails++; $display("FAIL envdn_on got %b want 1", channel_on);
        end
        write42(8'h00);
        cyc();
        tests++;
        if (channel_on !== 1'b0) begin
            fails++; $display("FAIL dac_off got %b want 0", channel_on);
        end
        trig(1'b0);
        cyc();
        tests++;
        if (channel_on !== 1'b0) begin
            fails++; $display("FAIL dac_off_trig got %b want 0", channel_on);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        noise_bit = 1'b1;
        write42(8'hF0);
        ticks(6);
        // Trigger and length-clock tick together with an expired counter.
        nr44 = 2'b11;
        nr44_write = 1'b1;
        frame_tick = 1'b1;
        cyc();
        nr44_write = 1'b0;
        frame_tick = 1'b0;
        tests++;
        if (dut.len_cnt_q !== 7'd64) begin
            fails++; $display("FAIL trig_tick_len got %0d want 64", dut.len_cnt_q);
        end
        tests++;
        if (dut.fs_step_q !== 3'd7) begin
            fails++; $display("FAIL trig_tick_fs got %0d want 7", dut.fs_step_q);
        end
        // Length load with trigger: the loaded value wins over the 64 reload.
        nr41 = 6'd60;
        nr41_write = 1'b1;
        nr44 = 2'b11;
        nr44_write = 1'b1;
        cyc();
        nr41_write = 1'b0;
        nr44_write = 1'b0;
        ticks(7);
        tests++;
        if (channel_on !== 1'b1) begin
            fails++; $display("FAIL len4_3clk got %b want 1", channel_on);
        end
        ticks(1);
        tests++;
        if (channel_on !== 1'b0) begin
            fails++; $display("FAIL len4_4clk got %b want 0", channel_on);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        noise_bit = 1'b1;
        // NR42 written in the trigger cycle is used by that trigger.
        nr42 = 8'h90;
        nr42_write = 1'b1;
        nr44 = 2'b10;
        nr44_write = 1'b1;
        cyc();
        nr42_write = 1'b0;
        nr44_write = 1'b0;
        cyc();
        tests++;
        if (amplitude !== 4'd9) begin
            fails++; $display("FAIL nr42_trig got %0d want 9", amplitude);
        end
        for (int i = 0; i < 8; i++) begin
            noise_bit = (i % 2 == 1);
            cyc();
            tests++;
            if (amplitude !== ((i % 2 == 1) ? 4'd9 : 4'd0)) begin
                fails++; $display("FAIL toggle%0d got %0d want %0d", i, amplitude,
                                  (i % 2 == 1) ? 9 : 0);
            end
        end
    endtask

    task automatic test_async_reset();
        noise_bit = 1'b1;
        ticks(3);
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (amplitude !== 4'd0 || channel_on !== 1'b0 || restart !== 1'b0) begin
            fails++; $display("FAIL async_reset got amp=%0d on=%b rs=%b want 0/0/0",
                              amplitude, channel_on, restart);
        end
        tests++;
        if (dut.fs_step_q !== 3'd0) begin
            fails++; $display("FAIL async_reset_fs got %0d want 0", dut.fs_step_q);
        end
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_trigger();
        test_length();
        test_env_up();
        test_env_down();
        test_simultaneous();
        test_toggle();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
